irq_arbiter: RTL and testbench
==============================

Name: irq_arbiter

Overview:
- Collects N external interrupt sources, latches rising edges as pending, applies a software-writable mask, and selects one winner by fixed priority.
- Drives the single-bit external interrupt input of the CP0 block.
- Sequences each interrupt through request, acknowledge and service phases, so a new interrupt is delivered only after ERET completes.
- Sits beside CP0 in the MEM-stage exception path and exposes the winning source ID for the cause register.

Parameters:
- N_SRC, 8, number of interrupt sources (2..32).
- ID_W, 3, width of the source ID; must satisfy 2**ID_W >= N_SRC.
- MASK_RST, {N_SRC{1'b0}}, reset value of the mask register (all sources disabled).

Ports:
- clk  in  1  main clock.
- rst  in  1  synchronous reset, active-high.
- irq_src  in  N_SRC  interrupt sources; synchronous to clk; edge-triggered.
- mask_we  in  1  mask write strobe (from a CP0 store in the EXE stage).
- mask_wdata  in  N_SRC  new mask value; bit=1 enables that source.
- mask  out  N_SRC  current mask register.
- pending  out  N_SRC  current pending register.
- ir_out  out  1  interrupt request to CP0 ir_in.
- ir_ack  in  1  CP0 has taken the interrupt (jump_en asserted with no ERET).
- eret  in  1  ERET executed in CP0.
- irq_id  out  ID_W  ID of the latched winner; valid while state != IDLE.
- busy  out  1  high in the REQ and SERVICE states.

Behaviour:
- Reset: all of the following load in the same cycle and override every other input.
  - mask <= MASK_RST; pending <= 0; src_prev <= 0.
  - state <= IDLE; ir_out <= 0; irq_id <= 0; busy <= 0.
- Edge detect:
  - rise[i] = irq_src[i] & ~src_prev[i].
  - src_prev <= irq_src every cycle.
- Pending update, per bit:
  - pending[i] <= rise[i] | (pending[i] & ~clr[i]).
  - clr[i] = (state==REQ) & ir_ack & (irq_id==i).
  - A new edge and a clear on the same bit in the same cycle: the set wins.
- Masking:
  - Masked edges are still recorded in pending. They are delivered once the bit is unmasked.
  - When mask_we is high, mask <= mask_wdata, effective from the next cycle.
- Priority: winner = lowest index i with (pending[i] & mask[i]).
- FSM, registered outputs:
  - IDLE: if any (pending & mask) bit is set: irq_id <= winner, ir_out <= 1, busy <= 1, go to REQ. Otherwise stay.
  - REQ: ir_out stays 1. On ir_ack: ir_out <= 0, clear pending[irq_id], go to SERVICE.
    - irq_id is frozen in REQ.
    - A mask change or a higher-priority edge during REQ does not preempt or withdraw the request.
  - SERVICE: ir_out = 0. On eret: busy <= 0, go to IDLE.
    - irq_id holds its value until the next grant.
    - eret and a new pending bit in the same cycle: go to IDLE. The new request is then raised one cycle later, never back-to-back in the same cycle.
- eret in IDLE or REQ is ignored. ir_ack outside REQ is ignored.
- Latency: rising edge sampled at clock edge k → pending set after k → ir_out high after edge k+1.
- All 32-bit-wide items are unaffected. Widths are N_SRC-bit only. Do not sign-extend irq_id; zero-pad when writing it into the cause register.
- A mid-operation reset in any state returns to IDLE with no pending bits and no output glitch (outputs are registers).

Decomposition:
- define.vh gains:
  - IRQ_ST_IDLE=2'd0, IRQ_ST_REQ=2'd1, IRQ_ST_SVC=2'd2.
  - A CP0 register index for the mask, CP0_IMR.
- One sub-module: irq_prio_enc, combinational.
  - Input: N_SRC request vector.
  - Outputs: ID_W index and a valid bit.
  - Lowest index wins.

Test Plan:
- Reset, then mask_we with 8'hFF; pulse irq_src[5] for 1 cycle → pending=8'h20 the next cycle; ir_out=1 and irq_id=5 one cycle later; ir_ack → pending=0, ir_out=0; eret → busy=0.
- irq_src[6] and irq_src[2] rise in the same cycle with mask=8'hFF → irq_id=2 first; after ack and eret, irq_id=6 is raised on the following grant.
- mask=8'h00, pulse irq_src[3] → pending=8'h08 and ir_out stays 0; write mask=8'h08 → ir_out=1 two cycles after the write, with irq_id=3.
- While in REQ with irq_id=4, pulse irq_src[0] → irq_id stays 4 with no preemption; after ack and eret, source 0 is served next.
- Hold the state in SERVICE, then assert eret while pending[1] is set → state IDLE for one cycle, then REQ with irq_id=1; also assert rst mid-REQ → ir_out=0, pending=0 and mask=0 the next cycle.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared FSM encoding and CP0 register index for the interrupt arbiter.
// Latency: n/a (types only); backpressure: n/a.
package irq_arbiter_pkg;

    typedef enum logic [1:0] {
        IRQ_ST_IDLE = 2'd0,
        IRQ_ST_REQ  = 2'd1,
        IRQ_ST_SVC  = 2'd2
    } irq_state_t;

    // CP0 register number that holds the interrupt mask
    localparam logic [4:0] CP0_IMR = 5'd22;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins.
// Latency: combinational; backpressure: none.
module irq_prio_enc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  idx,
    output logic             vld
);

    always_comb begin
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

    assign vld = |req;

endmodule

// File: rtl/irq_arbiter.sv
// Edge-latched, maskable, fixed-priority interrupt arbiter feeding CP0 ir_in.
// Latency: edge at k -> pending after k -> ir_out after k+1; holds request until ir_ack, next grant only after eret.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int               N_SRC    = 8,
    parameter int               ID_W     = 3,
    parameter logic [N_SRC-1:0] MASK_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic [N_SRC-1:0] mask,
    output logic [N_SRC-1:0] pending,
    output logic             ir_out,
    input  logic             ir_ack,
    input  logic             eret,
    output logic [ID_W-1:0]  irq_id,
    output logic             busy
);

    irq_state_t       state, state_nxt;
    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] pending_nxt;
    logic [ID_W-1:0]  win_id;
    logic             win_vld;
    logic             ir_out_nxt;
    logic             busy_nxt;
    logic [ID_W-1:0]  irq_id_nxt;

    assign rise = irq_src & ~src_prev;

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = (state == IRQ_ST_REQ) && ir_ack && (irq_id == ID_W'(i));
        end
    end

    // A fresh edge on the bit being acknowledged survives the clear
    assign pending_nxt = rise | (pending & ~clr);

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .req (pending & mask),
        .idx (win_id),
        .vld (win_vld)
    );

    always_comb begin
        state_nxt  = state;
        ir_out_nxt = ir_out;
        busy_nxt   = busy;
        irq_id_nxt = irq_id;
        case (state)
            IRQ_ST_IDLE: begin
                if (win_vld) begin
                    irq_id_nxt = win_id;
                    ir_out_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                    state_nxt  = IRQ_ST_REQ;
                end
            end
            IRQ_ST_REQ: begin
                if (ir_ack) begin
                    ir_out_nxt = 1'b0;
                    state_nxt  = IRQ_ST_SVC;
                end
            end
            IRQ_ST_SVC: begin
                ir_out_nxt = 1'b0;
                if (eret) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IRQ_ST_IDLE;
                end
            end
            default: begin
                ir_out_nxt = 1'b0;
                busy_nxt   = 1'b0;
                state_nxt  = IRQ_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask     <= MASK_RST;
            pending  <= '0;
            src_prev <= '0;
            state    <= IRQ_ST_IDLE;
            ir_out   <= 1'b0;
            irq_id   <= '0;
            busy     <= 1'b0;
        end else begin
            if (mask_we) begin
                mask <= mask_wdata;
            end
            pending  <= pending_nxt;
            src_prev <= irq_src;
            state    <= state_nxt;
            ir_out   <= ir_out_nxt;
            irq_id   <= irq_id_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: per-scenario tasks with hand-computed expectations.
module tb_irq_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_src;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       ir_out;
    logic       ir_ack;
    logic       eret;
    logic [2:0] irq_id;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    irq_arbiter #(
        .N_SRC    (8),
        .ID_W     (3),
        .MASK_RST (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .ir_out     (ir_out),
        .ir_ack     (ir_ack),
        .eret       (eret),
        .irq_id     (irq_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; irq_src = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00;
        ir_ack = 1'b0; eret = 1'b0;
        step(); step();
        rst = 1'b0;
        n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL reset_mask got=%h exp=00", mask); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL reset_pending got=%h exp=00", pending); end
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL reset_ir_out got=%b exp=0", ir_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (irq_id !== 3'd0) begin n_bad++; $display("FAIL reset_irq_id got=%0d exp=0", irq_id); end
    endtask

    task automatic test_single();
        mask_we = 1'b1; mask_wdata = 8'hFF;
        step();
        mask_we = 1'b0;
        n_cmp++; if (mask !== 8'hFF) begin n_bad++; $display("FAIL single_mask got=%h exp=ff", mask); end
        irq_src = 8'h20;
        step();
        irq_src = 8'h00;
        n_cmp++; if (pending !== 8'h20) begin n_bad++; $display("FAIL single_pending got=%h exp=20", pending); end
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL single_ir_early got=%b exp=0", ir_out); end
        step();
        n_cmp++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL single_ir_out got=%b exp=1", ir_out); end
        n_cmp++; if (irq_id !== 3'd5) begin n_bad++; $display("FAIL single_irq_id got=%0d exp=5", irq_id); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        step();
        n_cmp++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL single_ir_hold got=%b exp=1", ir_out); end
        ir_ack = 1'b1;
        step();
        ir_ack = 1'b0;
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL single_ack_pending got=%h exp=00", pending); end
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL single_ack_ir got=%b exp=0", ir_out); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_svc_busy got=%b exp=1", busy); end
        eret = 1'b1;
        step();
        eret = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_eret_busy got=%b exp=0", busy); end
        // Stray ack in IDLE must not start anything
        ir_ack = 1'b1;
        step();
        ir_ack = 1'b0;
        step();
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL idle_ack_ir got=%b exp=0", ir_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_ack_busy got=%b exp=0", busy); end
    endtask

    task automatic test_priority();
        irq_src = 8'h44;
        step();
        irq_src = 8'h00;
        step();
        n_cmp++; if (irq_id !== 3'd2) begin n_bad++; $display("FAIL prio_first_id got=%0d exp=2", irq_id); end
        n_cmp++; if (pending !== 8'h44) begin n_bad++; $display("FAIL prio_pending got=%h exp=44", pending); end
        ir_ack = 1'b1;
        step();
        ir_ack = 1'b0;
        n_cmp++; if (pending !== 8'h40) begin n_bad++; $display("FAIL prio_ack_pending got=%h exp=40", pending); end
        eret = 1'b1;
        step();
        eret = 1'b0;
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL prio_idle_ir got=%b exp=0", ir_out); end
        step();
        n_cmp++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL prio_second_ir got=%b exp=1", ir_out); end
        n_cmp++; if (irq_id !== 3'd6) begin n_bad++; $display("FAIL prio_second_id got=%0d exp=6", irq_id); end
        ir_ack = 1'b1; step(); ir_ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL prio_final_pending got=%h exp=00", pending); end
    endtask

    task automatic test_masked();
        mask_we = 1'b1; mask_wdata = 8'h00;
        step();
        mask_we = 1'b0;
        irq_src = 8'h08;
        step();
        irq_src = 8'h00;
        n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL masked_pending got=%h exp=08", pending); end
        step(); step();
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL masked_ir got=%b exp=0", ir_out); end
        mask_we = 1'b1; mask_wdata = 8'h08;
        step();
        mask_we = 1'b0;
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL unmask_ir_early got=%b exp=0", ir_out); end
        step();
        n_cmp++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL unmask_ir got=%b exp=1", ir_out); end
        n_cmp++; if (irq_id !== 3'd3) begin n_bad++; $display("FAIL unmask_id got=%0d exp=3", irq_id); end
        ir_ack = 1'b1; step(); ir_ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
        mask_we = 1'b1; mask_wdata = 8'hFF; step(); mask_we = 1'b0;
    endtask

    task automatic test_no_preempt();
        irq_src = 8'h10;
        step();
        irq_src = 8'h00;
        step();
        n_cmp++; if (irq_id !== 3'd4) begin n_bad++; $display("FAIL nopre_id got=%0d exp=4", irq_id); end
        irq_src = 8'h01;
        step();
        irq_src = 8'h00;
        n_cmp++; if (pending !== 8'h11) begin n_bad++; $display("FAIL nopre_pending got=%h exp=11", pending); end
        step();
        n_cmp++; if (irq_id !== 3'd4) begin n_bad++; $display("FAIL nopre_frozen_id got=%0d exp=4", irq_id); end
        n_cmp++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL nopre_ir got=%b exp=1", ir_out); end
        ir_ack = 1'b1;
        step();
        ir_ack = 1'b0;
        n_cmp++; if (pending !== 8'h01) begin n_bad++; $display("FAIL nopre_ack_pending got=%h exp=01", pending); end
        eret = 1'b1; step(); eret = 1'b0;
        step();
        n_cmp++; if (irq_id !== 3'd0) begin n_bad++; $display("FAIL nopre_next_id got=%0d exp=0", irq_id); end
        n_cmp++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL nopre_next_ir got=%b exp=1", ir_out); end
        ir_ack = 1'b1; step(); ir_ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic test_set_wins();
        irq_src = 8'h08;
        step();
        irq_src = 8'h00;
        step();
        n_cmp++; if (irq_id !== 3'd3) begin n_bad++; $display("FAIL setwin_id got=%0d exp=3", irq_id); end
        // New edge on the acknowledged source in the ack cycle
        irq_src = 8'h08; ir_ack = 1'b1;
        step();
        irq_src = 8'h00; ir_ack = 1'b0;
        n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL setwin_pending got=%h exp=08", pending); end
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL setwin_ir got=%b exp=0", ir_out); end
        eret = 1'b1; step(); eret = 1'b0;
        step();
        n_cmp++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL setwin_rereq got=%b exp=1", ir_out); end
        ir_ack = 1'b1; step(); ir_ack = 1'b0;
        eret = 1'b1; step(); eret = 1'b0;
    endtask

    task automatic test_back_to_back();
        irq_src = 8'h80;
        step();
        irq_src = 8'h00;
        step();
        ir_ack = 1'b1; step(); ir_ack = 1'b0;
        // eret while in REQ/IDLE would be ignored; here we are in SERVICE, held without eret
        step(); step();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL svc_hold_busy got=%b exp=1", busy); end
        irq_src = 8'h02;
        step();
        irq_src = 8'h00;
        n_cmp++; if (pending !== 8'h02) begin n_bad++; $display("FAIL svc_pending got=%h exp=02", pending); end
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL svc_ir got=%b exp=0", ir_out); end
        n_cmp++; if (irq_id !== 3'd7) begin n_bad++; $display("FAIL svc_id_hold got=%0d exp=7", irq_id); end
        eret = 1'b1;
        step();
        eret = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_ir got=%b exp=0", ir_out); end
        step();
        n_cmp++; if (ir_out !== 1'b1) begin n_bad++; $display("FAIL b2b_req_ir got=%b exp=1", ir_out); end
        n_cmp++; if (irq_id !== 3'd1) begin n_bad++; $display("FAIL b2b_req_id got=%0d exp=1", irq_id); end
        // Reset in the middle of REQ, with another source pending
        irq_src = 8'h04;
        step();
        irq_src = 8'h00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (ir_out !== 1'b0) begin n_bad++; $display("FAIL midrst_ir got=%b exp=0", ir_out); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL midrst_pending got=%h exp=00", pending); end
        n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL midrst_mask got=%h exp=00", mask); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_masked();
        test_no_preempt();
        test_set_wins();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
